tex_bus_arbiter: RTL
====================

// Module: tex_bus_arbiter
// PURPOSE
//  Shares one texture unit between NUM_INPUTS per-core texture agents.
//  - Requests: round-robin arbitration, source index appended to the tag, registered output.
//  - Responses: routed back to the issuing agent by the returned tag's index bits.
//  - A pending-request credit counter bounds in-flight work to MAX_PENDING.
// PARAMETERS
//  NUM_INPUTS   4   number of requesting agents (>=1)
//  REQ_DATAW    128 request payload width (mask, coords, lod, stage)
//  RSP_DATAW    128 response payload width (texels)
//  TAG_WIDTH    12  agent tag width (uuid + index-buffer slot)
//  MAX_PENDING  16  max requests in flight on the shared unit (>=1)
//  SEL_BITS = CLOG2(NUM_INPUTS) (derived); OTAG_W = TAG_WIDTH+SEL_BITS (derived)
// PORTS
//  clk            in   1                      clock
//  reset          in   1                      synchronous, active-high
//  req_valid_in   in   NUM_INPUTS             per-agent request valid
//  req_data_in    in   NUM_INPUTS*REQ_DATAW   per-agent request payload
//  req_tag_in     in   NUM_INPUTS*TAG_WIDTH   per-agent request tag
//  req_ready_in   out  NUM_INPUTS             per-agent request accepted
//  req_valid_out  out  1                      request to texture unit
//  req_data_out   out  REQ_DATAW              granted payload
//  req_tag_out    out  OTAG_W                 {tag, sel}; sel in LSBs
//  req_ready_out  in   1                      texture unit accepts
//  rsp_valid_in   in   1                      response from texture unit
//  rsp_data_in    in   RSP_DATAW              texels
//  rsp_tag_in     in   OTAG_W                 tag as issued
//  rsp_ready_in   out  1                      response accepted
//  rsp_valid_out  out  NUM_INPUTS             per-agent response valid
//  rsp_data_out   out  RSP_DATAW              shared response payload bus
//  rsp_tag_out    out  TAG_WIDTH              original agent tag (sel stripped)
//  rsp_ready_out  in   NUM_INPUTS             per-agent response ready
// BEHAVIOUR
//  Reset:
//  - req_valid_out=0, rsp_valid_out=0, rr_ptr=0, pending=0.
//  - Data/tag registers are don't-care while their valid is low.
//  Request stage (one output register):
//  - can_issue = (~req_valid_out | req_ready_out) & (pending < MAX_PENDING).
//  - Grant: first i at or after rr_ptr (mod NUM_INPUTS) with req_valid_in[i]. Only when can_issue.
//  - req_ready_in is one-hot at the granted index, 0 elsewhere. Combinational from valids, rr_ptr and can_issue.
//  - Latency: accepted in cycle T, visible on req_* at T+1. Held stable until req_ready_out.
//  - After a grant to i: rr_ptr <= (i+1) mod NUM_INPUTS. rr_ptr is unchanged if there is no grant.
//  - Throughput: one request per cycle sustained while req_ready_out=1 and credits remain.
//  - NUM_INPUTS==1: SEL_BITS=0, tag passes unmodified, no arbitration.
//  Credit counter (pending, CLOG2(MAX_PENDING+1) bits):
//  - +1 on grant; -1 on rsp_valid_in & rsp_ready_in; unchanged when both occur in the same cycle.
//  - At MAX_PENDING, all req_ready_in=0 until a response is accepted.
//  - The freed credit is usable in the same cycle as the response handshake (pending decrements first logically).
//  - Never underflows. A response with pending==0 is a protocol error: assertion only.
//  Response stage (one register):
//  - rsp_ready_in = ~rbuf_valid | rsp_ready_out[rbuf_sel].
//  - On accept, capture data, tag[OTAG_W-1:SEL_BITS] and sel=tag[SEL_BITS-1:0].
//  - rsp_valid_out[i] = rbuf_valid & (rbuf_sel==i). Stalls only on the addressed agent.
//  - Latency 1 cycle; full throughput when the target agent is ready.
//  - sel >= NUM_INPUTS is illegal: assertion only.
//  Mid-operation reset clears all state. In-flight texture-unit work is not tracked across reset.
// TESTING
//  1. NUM_INPUTS=4, all valid continuously, ready_out=1 -> grants 0,1,2,3,0 on consecutive cycles; tag LSBs 00,01,10,11.
//  2. Only agent 2 valid, tag 0x5A -> req_tag_out={0x5A,2'b10} one cycle later; rr_ptr becomes 3.
//  3. MAX_PENDING=2, no responses -> exactly 2 grants, then req_ready_in=0 forever. One response in -> one grant on the same cycle.
//  4. Response tag={0x123,2'b01} -> rsp_valid_out=4'b0010, rsp_tag_out=0x123 next cycle. With rsp_ready_out[1]=0, rsp_ready_in drops until released.
//  5. Grant and response in the same cycle at pending=MAX_PENDING-1 -> pending unchanged; no stall.
//  6. Assert reset with req_valid_out=1 and pending=5 -> next cycle all valids 0, pending=0, next grant starts at agent 0.

Source files
------------

// File: rtl/tex_bus_arbiter_if.sv
// ============================================================================
// Module      : tex_bus_arbiter_if
// Description : Agent-side and texture-unit-side bus bundle for tex_bus_arbiter
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tex_bus_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int REQ_DATAW  = 128,
    parameter int RSP_DATAW  = 128,
    parameter int TAG_WIDTH  = 12
);
    localparam int c_SEL_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
    localparam int c_OTAG_W   = TAG_WIDTH + c_SEL_BITS;

    logic [NUM_INPUTS-1:0]           req_valid_in;
    logic [NUM_INPUTS*REQ_DATAW-1:0] req_data_in;
    logic [NUM_INPUTS*TAG_WIDTH-1:0] req_tag_in;
    logic [NUM_INPUTS-1:0]           req_ready_in;
    logic                            req_valid_out;
    logic [REQ_DATAW-1:0]            req_data_out;
    logic [c_OTAG_W-1:0]             req_tag_out;
    logic                            req_ready_out;
    logic                            rsp_valid_in;
    logic [RSP_DATAW-1:0]            rsp_data_in;
    logic [c_OTAG_W-1:0]             rsp_tag_in;
    logic                            rsp_ready_in;
    logic [NUM_INPUTS-1:0]           rsp_valid_out;
    logic [RSP_DATAW-1:0]            rsp_data_out;
    logic [TAG_WIDTH-1:0]            rsp_tag_out;
    logic [NUM_INPUTS-1:0]           rsp_ready_out;

    modport slave (
        input  req_valid_in, req_data_in, req_tag_in,
        output req_ready_in,
        output req_valid_out, req_data_out, req_tag_out,
        input  req_ready_out,
        input  rsp_valid_in, rsp_data_in, rsp_tag_in,
        output rsp_ready_in,
        output rsp_valid_out, rsp_data_out, rsp_tag_out,
        input  rsp_ready_out
    );

    modport master (
        output req_valid_in, req_data_in, req_tag_in,
        input  req_ready_in,
        input  req_valid_out, req_data_out, req_tag_out,
        output req_ready_out,
        output rsp_valid_in, rsp_data_in, rsp_tag_in,
        input  rsp_ready_in,
        input  rsp_valid_out, rsp_data_out, rsp_tag_out,
        output rsp_ready_out
    );
endinterface

`default_nettype wire

// File: rtl/tex_bus_arbiter.sv
// ============================================================================
// Module      : tex_bus_arbiter
// Description : Round-robin request arbiter and tag-routed response demux
//               sharing one texture unit, with an in-flight credit limit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tex_bus_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int REQ_DATAW   = 128,
    parameter int RSP_DATAW   = 128,
    parameter int TAG_WIDTH   = 12,
    parameter int MAX_PENDING = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    tex_bus_arbiter_if.slave   bus
);
    localparam int c_SEL_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
    localparam int c_SEL_W    = (c_SEL_BITS > 0) ? c_SEL_BITS : 1;
    localparam int c_OTAG_W   = TAG_WIDTH + c_SEL_BITS;
    localparam int c_PEND_W   = $clog2(MAX_PENDING + 1);

    logic                  r_req_valid;
    logic [REQ_DATAW-1:0]  r_req_data;
    logic [c_OTAG_W-1:0]   r_req_tag;
    logic [c_SEL_W-1:0]    r_rr_ptr;
    logic [c_PEND_W-1:0]   r_pending;
    logic                  r_rsp_valid;
    logic [c_SEL_W-1:0]    r_rsp_sel;
    logic [RSP_DATAW-1:0]  r_rsp_data;
    logic [TAG_WIDTH-1:0]  r_rsp_tag;

    logic                  w_can_issue;
    logic                  w_grant;
    logic [c_SEL_W-1:0]    w_grant_idx;
    logic [c_SEL_W-1:0]    w_rr_next;
    logic [REQ_DATAW-1:0]  w_grant_data;
    logic [TAG_WIDTH-1:0]  w_grant_tag;
    logic [c_OTAG_W-1:0]   w_req_tag_next;
    logic                  w_rsp_fire;
    logic                  w_rsp_ready;
    logic                  w_sel_ready;
    logic [c_SEL_W-1:0]    w_rsp_sel_in;
    logic [TAG_WIDTH-1:0]  w_rsp_tag_in;

    // A response accepted this cycle frees its credit for a grant in the same cycle.
    assign w_rsp_ready = ~r_rsp_valid | w_sel_ready;
    assign w_rsp_fire  = bus.rsp_valid_in & w_rsp_ready;
    assign w_can_issue = (~r_req_valid | bus.req_ready_out)
                       & ((r_pending < c_PEND_W'(MAX_PENDING)) | w_rsp_fire);

    always_comb begin : p_grant
        logic [NUM_INPUTS-1:0] v_rot;
        logic [c_SEL_W:0]      v_sum;
        logic [c_SEL_W:0]      v_nxt;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        v_sum       = '0;
        v_rot       = NUM_INPUTS'({bus.req_valid_in, bus.req_valid_in} >> r_rr_ptr);
        // Scanning downward lets the lowest rotated offset win.
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (w_can_issue && v_rot[k]) begin
                v_sum = {1'b0, r_rr_ptr} + (c_SEL_W + 1)'(k);
                if (v_sum >= (c_SEL_W + 1)'(NUM_INPUTS)) begin
                    v_sum = v_sum - (c_SEL_W + 1)'(NUM_INPUTS);
                end
                w_grant     = 1'b1;
                w_grant_idx = v_sum[c_SEL_W-1:0];
            end
        end
        v_nxt = {1'b0, w_grant_idx} + (c_SEL_W + 1)'(1);
        if (v_nxt >= (c_SEL_W + 1)'(NUM_INPUTS)) begin
            v_nxt = v_nxt - (c_SEL_W + 1)'(NUM_INPUTS);
        end
        w_rr_next = v_nxt[c_SEL_W-1:0];
    end

    always_comb begin : p_req_mux
        w_grant_data = '0;
        w_grant_tag  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_grant_idx == c_SEL_W'(i)) begin
                w_grant_data = bus.req_data_in[i*REQ_DATAW +: REQ_DATAW];
                w_grant_tag  = bus.req_tag_in[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    generate
        if (c_SEL_BITS > 0) begin : g_multi
            assign w_req_tag_next = {w_grant_tag, w_grant_idx};
            assign w_rsp_sel_in   = bus.rsp_tag_in[c_SEL_BITS-1:0];
            assign w_rsp_tag_in   = bus.rsp_tag_in[c_OTAG_W-1:c_SEL_BITS];
            assign w_sel_ready    = bus.rsp_ready_out[r_rsp_sel];

            a_sel_legal : assert property (@(posedge clk) disable iff (reset)
                w_rsp_fire |-> (int'(w_rsp_sel_in) < NUM_INPUTS));
        end else begin : g_single
            assign w_req_tag_next = w_grant_tag;
            assign w_rsp_sel_in   = '0;
            assign w_rsp_tag_in   = bus.rsp_tag_in;
            assign w_sel_ready    = bus.rsp_ready_out[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_pending   <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_grant) begin
                r_req_valid <= 1'b1;
                r_rr_ptr    <= w_rr_next;
            end else if (bus.req_ready_out) begin
                r_req_valid <= 1'b0;
            end

            if (w_grant && !w_rsp_fire) begin
                r_pending <= r_pending + c_PEND_W'(1);
            end else if (!w_grant && w_rsp_fire && (r_pending != '0)) begin
                r_pending <= r_pending - c_PEND_W'(1);
            end

            if (w_rsp_fire) begin
                r_rsp_valid <= 1'b1;
            end else if (w_sel_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by their valids.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_req_data <= w_grant_data;
            r_req_tag  <= w_req_tag_next;
        end
        if (w_rsp_fire) begin
            r_rsp_data <= bus.rsp_data_in;
            r_rsp_tag  <= w_rsp_tag_in;
            r_rsp_sel  <= w_rsp_sel_in;
        end
    end

    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        w_rsp_fire |-> (r_pending != '0));

    assign bus.req_ready_in  = w_grant ? (NUM_INPUTS'(1) << w_grant_idx) : '0;
    assign bus.req_valid_out = r_req_valid;
    assign bus.req_data_out  = r_req_data;
    assign bus.req_tag_out   = r_req_tag;
    assign bus.rsp_ready_in  = w_rsp_ready;
    assign bus.rsp_valid_out = r_rsp_valid ? (NUM_INPUTS'(1) << r_rsp_sel) : '0;
    assign bus.rsp_data_out  = r_rsp_data;
    assign bus.rsp_tag_out   = r_rsp_tag;

endmodule

`default_nettype wire
